// File: rtl/ecall_sequencer.sv
// Multi-cycle ecall controller: freezes PC/reg_file, dispatches on the a7 service
// code, performs print/read/exit I/O with a debounced confirm button, then releases.
module ecall_sequencer #(
  parameter int DEBOUNCE_CYCLES = 230000,
  parameter int CNT_W           = 18
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] service_i,
  input  logic        finish_i,
  output logic        stall_o,
  output logic [1:0]  io_sel_o,
  output logic        io_wen_o,
  output logic        out_strobe_o,
  output logic        halted_o,
  output logic        service_err_o,
  output logic [2:0]  state_dbg_o
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PRINT      = 3'd1,
    S_WAIT_REL   = 3'd2,
    S_WAIT_PRESS = 3'd3,
    S_COMMIT     = 3'd4,
    S_RELEASE    = 3'd5,
    S_HALT       = 3'd6
  } state_t;

  localparam logic [6:0]       OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0]       F3_ECALL   = 3'b000;
  localparam logic [1:0]       SEL_ALU    = 2'b00;
  localparam logic [1:0]       SEL_SWITCH = 2'b01;
  localparam logic [1:0]       SEL_KEYB   = 2'b10;
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             err_q, err_d;
  logic             sync1_q, fin_s_q;

  logic ecall_hit;
  logic upper_zero;
  logic stall;
  logic io_wen;
  logic out_strobe;

  assign ecall_hit  = (opcode_i == OPC_SYSTEM) && (funct3_i == F3_ECALL);
  assign upper_zero = (service_i[31:4] == 28'd0);

  // Two-flop synchronizer; the raw button is never used past this point.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      fin_s_q <= 1'b0;
    end else begin
      sync1_q <= finish_i;
      fin_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= SEL_ALU;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    sel_d      = sel_q;
    err_d      = err_q;
    stall      = 1'b0;
    io_wen     = 1'b0;
    out_strobe = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ecall_hit) begin
          stall = 1'b1;
          if (!upper_zero) begin
            state_d = S_RELEASE;
            err_d   = 1'b1;
          end else begin
            case (service_i[3:0])
              4'd1:  state_d = S_PRINT;
              4'd5: begin
                state_d = S_WAIT_REL;
                sel_d   = SEL_SWITCH;
              end
              4'd6: begin
                state_d = S_WAIT_REL;
                sel_d   = SEL_KEYB;
              end
              4'd10: state_d = S_HALT;
              default: begin
                state_d = S_RELEASE;
                err_d   = 1'b1;
              end
            endcase
          end
        end
      end

      S_PRINT: begin
        stall      = 1'b1;
        out_strobe = 1'b1;
        state_d    = S_RELEASE;
      end

      // Terminal count is reached on the cycle the counter already holds
      // DEBOUNCE_CYCLES-1 matching samples and the current sample also matches.
      S_WAIT_REL: begin
        stall = 1'b1;
        if (!fin_s_q) begin
          if (cnt_q == DB_LAST) begin
            state_d = S_WAIT_PRESS;
          end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          end
        end
      end

      S_WAIT_PRESS: begin
        stall = 1'b1;
        if (fin_s_q) begin
          if (cnt_q == DB_LAST) begin
            state_d = S_COMMIT;
          end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          end
        end
      end

      S_COMMIT: begin
        stall   = 1'b1;
        io_wen  = 1'b1;
        state_d = S_RELEASE;
      end

      S_RELEASE: begin
        sel_d   = SEL_ALU;
        state_d = S_IDLE;
      end

      S_HALT: begin
        stall = 1'b1;
      end

      default: begin
        sel_d   = SEL_ALU;
        state_d = S_IDLE;
      end
    endcase
  end

  assign stall_o       = stall;
  assign io_sel_o      = sel_q;
  assign io_wen_o      = io_wen;
  assign out_strobe_o  = out_strobe;
  assign halted_o      = (state_q == S_HALT);
  assign service_err_o = err_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_ecall_sequencer.sv
// Directed bench for ecall_sequencer with a short debounce window (4 cycles).
module tb_ecall_sequencer;

  localparam logic [6:0] OPC_ALU = 7'b0110011;
  localparam logic [6:0] OPC_SYS = 7'b1110011;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] service_i;
  logic        finish_i;
  logic        stall_o;
  logic [1:0]  io_sel_o;
  logic        io_wen_o;
  logic        out_strobe_o;
  logic        halted_o;
  logic        service_err_o;
  logic [2:0]  state_dbg_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  ecall_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .opcode_i      (opcode_i),
    .funct3_i      (funct3_i),
    .service_i     (service_i),
    .finish_i      (finish_i),
    .stall_o       (stall_o),
    .io_sel_o      (io_sel_o),
    .io_wen_o      (io_wen_o),
    .out_strobe_o  (out_strobe_o),
    .halted_o      (halted_o),
    .service_err_o (service_err_o),
    .state_dbg_o   (state_dbg_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each cycle begins at a falling edge: drive inputs, settle, then sample.
  task automatic begin_cycle(input logic [6:0] opc, input logic [31:0] svc, input logic fin);
    @(negedge clk_i);
    opcode_i  = opc;
    service_i = svc;
    finish_i  = fin;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i    = 1'b1;
    opcode_i = OPC_ALU;
    finish_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
  endtask

  // Cycle 0 presents the ecall; pat[k] is the raw button level in cycle k.
  task automatic run_io(input string tag, input logic [31:0] svc, input logic [39:0] pat,
                        input int exp_commit, input logic [1:0] exp_sel,
                        input int probe, input logic [2:0] probe_state);
    int   pulses = 0;
    int   at = -1;
    logic [1:0] sel_at = 2'b00;
    logic stall_after = 1'b1;
    for (int k = 0; k < 40; k++) begin
      begin_cycle((k == 0) ? OPC_SYS : OPC_ALU, svc, pat[k]);
      if (io_wen_o) begin
        pulses++;
        at     = k;
        sel_at = io_sel_o;
      end
      if (k == exp_commit + 1) stall_after = stall_o;
      if (k == probe) begin
        check_eq({tag, "_probe_state"}, 32'(state_dbg_o), 32'(probe_state));
        check_eq({tag, "_probe_sel"}, 32'(io_sel_o), 32'(exp_sel));
      end
    end
    check_eq({tag, "_wen_pulses"}, 32'(pulses), 32'd1);
    check_eq({tag, "_wen_cycle"}, 32'(at), 32'(exp_commit));
    check_eq({tag, "_sel_at_wen"}, 32'(sel_at), 32'(exp_sel));
    check_eq({tag, "_stall_after"}, 32'(stall_after), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   cnt;
    logic bad;

    rst_i     = 1'b1;
    opcode_i  = OPC_ALU;
    funct3_i  = 3'b000;
    service_i = 32'd0;
    finish_i  = 1'b0;

    // Reset values
    do_reset();
    check_eq("rst_state", 32'(state_dbg_o), 32'd0);
    check_eq("rst_stall", 32'(stall_o), 32'd0);
    check_eq("rst_outs", {27'd0, io_sel_o, io_wen_o, out_strobe_o, halted_o}, 32'd0);
    check_eq("rst_err", 32'(service_err_o), 32'd0);

    // Print
    begin_cycle(OPC_SYS, 32'd1, 1'b0);
    check_eq("prt_c0_stall", 32'(stall_o), 32'd1);
    check_eq("prt_c0_strobe", 32'(out_strobe_o), 32'd0);
    begin_cycle(OPC_ALU, 32'd0, 1'b0);
    check_eq("prt_c1_stall", 32'(stall_o), 32'd1);
    check_eq("prt_c1_strobe", 32'(out_strobe_o), 32'd1);
    begin_cycle(OPC_ALU, 32'd0, 1'b0);
    check_eq("prt_c2_stall", 32'(stall_o), 32'd0);
    check_eq("prt_c2_strobe", 32'(out_strobe_o), 32'd0);
    check_eq("prt_c2_state", 32'(state_dbg_o), 32'd5);
    begin_cycle(OPC_ALU, 32'd0, 1'b0);
    check_eq("prt_c3_state", 32'(state_dbg_o), 32'd0);

    // ecall opcode with a non-zero funct3 is not an ecall
    begin_cycle(OPC_SYS, 32'd1, 1'b0);
    funct3_i = 3'b001;
    #1;
    check_eq("f3_stall", 32'(stall_o), 32'd0);
    begin_cycle(OPC_ALU, 32'd0, 1'b0);
    funct3_i = 3'b000;
    #1;
    check_eq("f3_state", 32'(state_dbg_o), 32'd0);

    // Read switch with a 2-cycle glitch during WAIT_PRESS
    run_io("sw", 32'd5, 40'h000001F8C0, 17, 2'b01, 12, 3'd3);

    // Held button: already pressed when the ecall arrives
    repeat (3) begin_cycle(OPC_ALU, 32'd0, 1'b1);
    run_io("kb", 32'd6, 40'h0003FF01FF, 22, 2'b10, 8, 3'd2);

    // Back-to-back ecalls: the one present during RELEASE is ignored
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      begin_cycle((k < 5) ? OPC_SYS : OPC_ALU, 32'd1, 1'b0);
      if (out_strobe_o) cnt++;
      if (k == 2) check_eq("b2b_rel_stall", 32'(stall_o), 32'd0);
      if (k == 3) check_eq("b2b_idle_stall", 32'(stall_o), 32'd1);
      if (k == 4) check_eq("b2b_strobe2", 32'(out_strobe_o), 32'd1);
    end
    check_eq("b2b_strobes", 32'(cnt), 32'd2);

    // Unknown code
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      begin_cycle((k == 0) ? OPC_SYS : OPC_ALU, 32'd7, 1'b0);
      if (io_wen_o || out_strobe_o) cnt++;
      if (k == 0) check_eq("unk_c0_stall", 32'(stall_o), 32'd1);
      if (k == 1) begin
        check_eq("unk_c1_stall", 32'(stall_o), 32'd0);
        check_eq("unk_c1_err", 32'(service_err_o), 32'd1);
      end
    end
    check_eq("unk_no_action", 32'(cnt), 32'd0);
    check_eq("unk_state", 32'(state_dbg_o), 32'd0);
    begin_cycle(OPC_SYS, 32'd1, 1'b0);
    begin_cycle(OPC_ALU, 32'd0, 1'b0);
    check_eq("unk_sticky", 32'(service_err_o), 32'd1);

    // Upper bits set with a valid low nibble is still an unknown code
    do_reset();
    check_eq("rst2_err", 32'(service_err_o), 32'd0);
    begin_cycle(OPC_SYS, 32'h15, 1'b0);
    begin_cycle(OPC_ALU, 32'd0, 1'b0);
    check_eq("upper_err", 32'(service_err_o), 32'd1);
    check_eq("upper_state", 32'(state_dbg_o), 32'd5);
    check_eq("upper_sel", 32'(io_sel_o), 32'd0);

    // Exit
    begin_cycle(OPC_ALU, 32'd0, 1'b0);
    begin_cycle(OPC_SYS, 32'd10, 1'b0);
    check_eq("hlt_c0_stall", 32'(stall_o), 32'd1);
    bad = 1'b0;
    for (int k = 0; k < 100; k++) begin
      begin_cycle(OPC_ALU, 32'd0, 1'($urandom_range(0, 1)));
      if (!stall_o || !halted_o || state_dbg_o != 3'd6 || io_wen_o) bad = 1'b1;
    end
    check_eq("hlt_stuck", 32'(bad), 32'd0);
    do_reset();
    check_eq("hlt_rst_halted", 32'(halted_o), 32'd0);
    check_eq("hlt_rst_state", 32'(state_dbg_o), 32'd0);

    // Reset in WAIT_PRESS with counter at 3 (commit would follow next cycle)
    cnt = 0;
    for (int k = 0; k < 11; k++) begin
      begin_cycle((k == 0) ? OPC_SYS : OPC_ALU, 32'd5, (k >= 5));
      if (io_wen_o) cnt++;
    end
    check_eq("mid_pre_state", 32'(state_dbg_o), 32'd3);
    rst_i = 1'b1;
    begin_cycle(OPC_ALU, 32'd0, 1'b1);
    rst_i = 1'b0;
    #1;
    check_eq("mid_state", 32'(state_dbg_o), 32'd0);
    check_eq("mid_sel", 32'(io_sel_o), 32'd0);
    if (io_wen_o) cnt++;
    for (int k = 0; k < 10; k++) begin
      begin_cycle(OPC_ALU, 32'd0, 1'b1);
      if (io_wen_o) cnt++;
    end
    check_eq("mid_no_wen", 32'(cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ecall_sequencer.md
Name: ecall_sequencer

Overview:
- Multi-cycle controller that sequences the single-cycle core's datapath whenever an ecall is decoded.
- Freezes the PC and register file, dispatches on the service code held in a7, and performs the I/O action:
  - print: strobe display latch
  - read switches / read keyboard: select write-back source and pulse write enable after a debounced confirm press
  - exit: halt
- Releases the core after the action completes.
- Sits between the decoder outputs, the finish button and the pc/reg_file stop inputs.

Parameters:
- DEBOUNCE_CYCLES, 230000, consecutive stable synchronized cycles required to accept a finish level (about 10 ms at 23 MHz).
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  core clock, 23 MHz; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- opcode  input  7  decoded opcode of current instruction.
- funct3  input  3  decoded funct3.
- service  input  32  value of register a7 (x17) read this cycle.
- finish  input  1  raw, asynchronous confirm button.
- stall  output  1  high: PC holds and reg_file ignores normal writes.
- io_sel  output  2  write-back source: 00 ALU, 01 switch, 10 keyboard.
- io_wen  output  1  one-cycle write enable for a0 from the io_sel source.
- out_strobe  output  1  one-cycle pulse: display latches a0.
- halted  output  1  program exited.
- service_err  output  1  sticky: unknown service code seen.
- state_dbg  output  3  current state encoding, for LED debug.

Behaviour:
- Reset: state IDLE, io_sel 00, io_wen 0, out_strobe 0, halted 0, service_err 0, debounce counter 0, synchronizer flops 0.
- Reset mid-operation returns to IDLE in the next cycle; any pending write or strobe is abandoned.
- ecall_hit = (opcode == 7'b1110011) and (funct3 == 3'b000).
- stall is combinational:
  - high when state != IDLE and state != RELEASE;
  - high in IDLE when ecall_hit;
  - low otherwise, so the PC advances past the ecall at the end of the RELEASE cycle.
- finish passes through a 2-flop synchronizer (fin_s). All debounce logic uses fin_s only.
- Debounce counter:
  - in WAIT_REL, counts consecutive cycles with fin_s == 0;
  - in WAIT_PRESS, counts consecutive cycles with fin_s == 1;
  - clears on any mismatch and on every state change;
  - saturates; never wraps.
- States, encoding 0..6:
  - IDLE(0): on ecall_hit, latch service[3:0] and check service[31:4] == 0, then dispatch:
    - code 1 -> PRINT;
    - code 5 -> WAIT_REL with io_sel latched 01;
    - code 6 -> WAIT_REL with io_sel latched 10;
    - code 10 -> HALT;
    - any other value -> RELEASE, setting service_err.
  - PRINT(1): out_strobe = 1 for exactly this cycle -> RELEASE.
  - WAIT_REL(2): wait until fin_s has been 0 for DEBOUNCE_CYCLES -> WAIT_PRESS. A button already held when the ecall arrives is ignored until released.
  - WAIT_PRESS(3): wait until fin_s has been 1 for DEBOUNCE_CYCLES -> COMMIT.
  - COMMIT(4): io_wen = 1 for exactly this cycle with io_sel stable. stall stays high -> RELEASE.
  - RELEASE(5): io_sel returns to 00 at the end of this cycle. Always -> IDLE. A new ecall_hit is not evaluated in RELEASE.
  - HALT(6): halted = 1, stall = 1. Leaves only on rst. finish is ignored.
- io_sel holds its latched value from WAIT_REL entry through COMMIT; it is 00 in all other states.
- Back-to-back ecalls: the second one is sampled in IDLE, in the cycle after RELEASE.
- A bounce shorter than DEBOUNCE_CYCLES never advances WAIT_REL or WAIT_PRESS.

Test Plan:
- DEBOUNCE_CYCLES=4 for all scenarios. Reset: rst high for 2 cycles -> all outputs 0, state_dbg=0, stall=0 with opcode=0110011.
- Print: ecall with service=1 -> stall high in cycles 0 and 1, out_strobe high only in cycle 1, stall low in cycle 2 (RELEASE), state_dbg back to 0 in cycle 3.
- Read switch with bounce:
  - Stimulus: service=5, finish low 6 cycles, then a 2-cycle high glitch, then low 3 cycles, then high 6 cycles.
  - Response: the glitch does not reach COMMIT; io_wen pulses once, with io_sel=01, exactly 2 (sync) + 4 cycles after the stable rise; stall is low in the following cycle.
- Held button: service=6 with finish already high at ecall -> remains in WAIT_REL, io_sel=10, until finish low for ≥4 synced cycles; a subsequent stable press produces a single io_wen.
- Exit and unknown code:
  - service=10 -> halted=1, stall stuck at 1 for 100 cycles regardless of finish; rst clears.
  - service=7 -> service_err=1 sticky, single stall cycle, no io_wen or out_strobe.
- Reset mid-wait: rst asserted in WAIT_PRESS with counter at 3 -> next cycle IDLE, io_sel=00, no io_wen ever emitted for that ecall.
